// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: op encodings,
// FSM state type, step-mode type and small op-classification helpers.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } step_mode_t;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// Request/result bundle between the issue stage and the HI/LO multiply/divide
// controller; the issue side is the master, the controller the slave.
interface muldiv_hilo_ctrl_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, Hi, Lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of unsigned shift-add multiply or restoring
// divide on a 2*WIDTH partial register ({acc, multiplier} or {rem, quot}).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  step_mode_t         mode,
    input  logic [2*WIDTH-1:0] partial,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] partial_next
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] rem_shifted;
    logic [WIDTH:0] trial;

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        mul_sum      = {1'b0, partial[2*WIDTH-1:WIDTH]};
        rem_shifted  = partial[2*WIDTH-1:WIDTH-1];
        trial        = rem_shifted - {1'b0, operand};
        partial_next = partial;

        if (mode == MODE_MUL) begin
            if (partial[0]) begin
                mul_sum = {1'b0, partial[2*WIDTH-1:WIDTH]} + {1'b0, operand};
            end
            // The add carry becomes the new top bit as the product shifts right.
            partial_next = {mul_sum, partial[WIDTH-1:1]};
        end else begin
            if (!trial[WIDTH]) begin
                partial_next = {trial[WIDTH-1:0], partial[WIDTH-2:0], 1'b1};
            end else begin
                partial_next = {rem_shifted[WIDTH-1:0], partial[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MIPS multiply/divide controller owning HI/LO. Define
// MULDIV_MADD_EN to enable MADD/MSUB (op 100/101) and the 64-bit accumulator.
module muldiv_hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               Clk,
    input  logic               Reset,
    muldiv_hilo_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [2:0]         op_q;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] partial_step;
    logic [WIDTH-1:0]   operand;
    logic               res_neg;
    logic               rem_neg;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               accept_long;
    logic               accept_move;
    logic               in_signed;
    logic               in_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    step_mode_t         step_mode;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    // Request decode: only meaningful in IDLE; anything else is ignored.
    always_comb begin
        accept_long = 1'b0;
        accept_move = 1'b0;
        if (state == IDLE && bus.Start) begin
            case (bus.Op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: accept_long = 1'b1;
`ifdef MULDIV_MADD_EN
                OP_MADD, OP_MSUB:                   accept_long = 1'b1;
`endif
                OP_MTHI, OP_MTLO:                   accept_move = 1'b1;
                default:                            accept_long = 1'b0;
            endcase
        end
    end

    always_comb begin
        in_signed = op_is_signed(bus.Op);
        in_div    = op_is_div(bus.Op);
        a_neg     = in_signed & bus.A[WIDTH-1];
        b_neg     = in_signed & bus.B[WIDTH-1];
        mag_a     = a_neg ? -bus.A : bus.A;
        mag_b     = b_neg ? -bus.B : bus.B;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_long) state_next = RUN;
            RUN:     if (count == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign step_mode = op_is_div(op_q) ? MODE_DIV : MODE_MUL;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode         (step_mode),
        .partial      (partial),
        .operand      (operand),
        .partial_next (partial_step)
    );

    // Sign correction and HI/LO result selection for the FIX cycle.
    always_comb begin
        prod_fix = res_neg ? -partial : partial;
        quot_fix = res_neg ? -partial[WIDTH-1:0] : partial[WIDTH-1:0];
        rem_fix  = rem_neg ? -partial[2*WIDTH-1:WIDTH] : partial[2*WIDTH-1:WIDTH];
        hi_fix   = hi_q;
        lo_fix   = lo_q;
        case (op_q)
            OP_DIV, OP_DIVU: {hi_fix, lo_fix} = {rem_fix, quot_fix};
`ifdef MULDIV_MADD_EN
            OP_MADD:         {hi_fix, lo_fix} = {hi_q, lo_q} + prod_fix;
            OP_MSUB:         {hi_fix, lo_fix} = {hi_q, lo_q} - prod_fix;
`endif
            default:         {hi_fix, lo_fix} = prod_fix;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            count   <= '0;
            op_q    <= OP_MULT;
            partial <= '0;
            operand <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next != IDLE);
            done_q <= (state == FIX);

            if (accept_long) begin
                op_q    <= bus.Op;
                count   <= CNT_W'(WIDTH - 1);
                partial <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
                operand <= in_div ? mag_b : mag_a;
                // A zero divisor must leave the all-ones quotient unnegated.
                res_neg <= (a_neg ^ b_neg) & ~(in_div & (bus.B == '0));
                rem_neg <= in_div & a_neg;
            end

            if (accept_move) begin
                if (bus.Op == OP_MTHI) hi_q <= bus.A;
                else                   lo_q <= bus.A;
            end

            if (state == RUN) begin
                partial <= partial_step;
                count   <= count - CNT_W'(1);
            end

            if (state == FIX) begin
                hi_q <= hi_fix;
                lo_q <= lo_fix;
            end
        end
    end

    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed self-checking bench for muldiv_hilo_ctrl; MADD/MSUB vectors apply
// when MULDIV_MADD_EN is defined, otherwise op 100/101 must be ignored.
module tb_muldiv_hilo_ctrl;
    import muldiv_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    muldiv_hilo_ctrl_if #(.WIDTH(32)) bus ();

    muldiv_hilo_ctrl #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Starts at a negedge; returns at the negedge where Done is seen (or after the bound).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles, output int done_idx);
        bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
        @(negedge Clk);
        bus.Start = 1'b0;
        busy_cycles = 0;
        done_idx    = -1;
        for (int idx = 1; idx <= 100; idx++) begin
            if (bus.Busy) busy_cycles++;
            if (bus.Done) begin
                done_idx = idx;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic check_result(input string name, input int done_idx,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        n_checks++;
        if (done_idx !== 34) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d, required 34", name, done_idx);
        end
        n_checks++;
        if (bus.Hi !== exp_hi) begin
            n_fail++;
            $display("FAIL %s hi: got %h, required %h", name, bus.Hi, exp_hi);
        end
        n_checks++;
        if (bus.Lo !== exp_lo) begin
            n_fail++;
            $display("FAIL %s lo: got %h, required %h", name, bus.Lo, exp_lo);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.Start = 1'b0; bus.Op = OP_MULT; bus.A = '0; bus.B = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        n_checks++;
        if ({bus.Busy, bus.Done, bus.Hi, bus.Lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, required all zero",
                     bus.Busy, bus.Done, bus.Hi, bus.Lo);
        end
    endtask

    task automatic test_mult();
        int busy_cycles, done_idx;
        run_op(OP_MULT, 32'hFFFF_FFFC, 32'd3, busy_cycles, done_idx);
        n_checks++;
        if (busy_cycles !== 33) begin
            n_fail++;
            $display("FAIL mult_busy_len: got %0d, required 33", busy_cycles);
        end
        n_checks++;
        if (bus.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_busy_at_done: got %b, required 0", bus.Busy);
        end
        check_result("mult_neg4x3", done_idx, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
        @(negedge Clk);
        n_checks++;
        if (bus.Done !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_done_width: got %b, required 0", bus.Done);
        end
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, busy_cycles, done_idx);
        check_result("mult_minxmin", done_idx, 32'h4000_0000, 32'h0000_0000);
    endtask

    task automatic test_multu();
        int busy_cycles, done_idx;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy_cycles, done_idx);
        check_result("multu_max", done_idx, 32'hFFFF_FFFE, 32'h0000_0001);
    endtask

    task automatic test_div();
        int busy_cycles, done_idx;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, busy_cycles, done_idx);
        check_result("div_neg7_2", done_idx, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, busy_cycles, done_idx);
        check_result("div_7_neg2", done_idx, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, busy_cycles, done_idx);
        check_result("div_overflow", done_idx, 32'h0000_0000, 32'h8000_0000);
    endtask

    task automatic test_div_zero();
        int busy_cycles, done_idx;
        run_op(OP_DIVU, 32'd7, 32'd0, busy_cycles, done_idx);
        check_result("divu_by_zero", done_idx, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, busy_cycles, done_idx);
        check_result("div_neg_by_zero", done_idx, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    endtask

    task automatic test_move();
        logic [31:0] hi_before;
        hi_before = bus.Hi;
        bus.Start = 1'b1; bus.Op = OP_MTLO; bus.A = 32'd5; bus.B = 32'd0;
        @(negedge Clk);
        bus.Start = 1'b0;
        n_checks++;
        if (bus.Lo !== 32'd5) begin
            n_fail++;
            $display("FAIL mtlo_value: got %h, required 00000005", bus.Lo);
        end
        n_checks++;
        if ({bus.Busy, bus.Done} !== 2'b00) begin
            n_fail++;
            $display("FAIL mtlo_flags: got busy=%b done=%b, required 0 0", bus.Busy, bus.Done);
        end
        n_checks++;
        if (bus.Hi !== hi_before) begin
            n_fail++;
            $display("FAIL mtlo_hi_kept: got %h, required %h", bus.Hi, hi_before);
        end
        bus.Start = 1'b1; bus.Op = OP_MTHI; bus.A = 32'h1234_5678;
        @(negedge Clk);
        bus.Start = 1'b0;
        n_checks++;
        if ({bus.Hi, bus.Lo, bus.Busy} !== {32'h1234_5678, 32'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL mthi_value: got hi=%h lo=%h busy=%b, required 12345678 00000005 0",
                     bus.Hi, bus.Lo, bus.Busy);
        end
    endtask

    task automatic test_start_while_busy();
        int done_idx;
        bus.Start = 1'b1; bus.Op = OP_DIVU; bus.A = 32'd100; bus.B = 32'd7;
        @(negedge Clk);
        bus.Start = 1'b0;
        done_idx = -1;
        for (int idx = 1; idx <= 100; idx++) begin
            if (idx == 5) begin
                bus.Start = 1'b1; bus.Op = OP_MTHI; bus.A = 32'd9; bus.B = 32'd3;
            end else begin
                bus.Start = 1'b0;
            end
            if (bus.Done) begin
                done_idx = idx;
                break;
            end
            @(negedge Clk);
        end
        bus.Start = 1'b0;
        check_result("start_while_busy", done_idx, 32'd2, 32'd14);
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        bus.Start = 1'b1; bus.Op = OP_MULT; bus.A = 32'd5; bus.B = 32'd6;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge Clk);
        n_checks++;
        if (bus.Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy_before: got %b, required 1", bus.Busy);
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        n_checks++;
        if ({bus.Busy, bus.Done, bus.Hi, bus.Lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_mid_state: got busy=%b done=%b hi=%h lo=%h, required all zero",
                     bus.Busy, bus.Done, bus.Hi, bus.Lo);
        end
        seen = 1'b0;
        for (int idx = 0; idx < 40; idx++) begin
            if (bus.Busy || bus.Done) seen = 1'b1;
            @(negedge Clk);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got activity=%b, required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int busy_cycles, done_idx;
        run_op(OP_MULTU, 32'd6, 32'd7, busy_cycles, done_idx);
        check_result("b2b_first", done_idx, 32'd0, 32'd42);
        run_op(OP_DIVU, 32'd100, 32'd7, busy_cycles, done_idx);
        n_checks++;
        if (busy_cycles !== 33) begin
            n_fail++;
            $display("FAIL b2b_busy_len: got %0d, required 33", busy_cycles);
        end
        check_result("b2b_second", done_idx, 32'd2, 32'd14);
    endtask

`ifdef MULDIV_MADD_EN
    task automatic test_madd();
        int busy_cycles, done_idx;
        bus.Start = 1'b1; bus.Op = OP_MTHI; bus.A = 32'd0;
        @(negedge Clk);
        bus.Op = OP_MTLO; bus.A = 32'd10;
        @(negedge Clk);
        bus.Start = 1'b0;
        run_op(OP_MADD, 32'd3, 32'd4, busy_cycles, done_idx);
        check_result("madd_3x4", done_idx, 32'd0, 32'd22);
        run_op(OP_MSUB, 32'd2, 32'd11, busy_cycles, done_idx);
        check_result("msub_2x11", done_idx, 32'd0, 32'd0);
        run_op(OP_MADD, 32'hFFFF_FFFF, 32'd1, busy_cycles, done_idx);
        check_result("madd_neg1", done_idx, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask
`else
    task automatic test_madd_ignored();
        bit seen;
        logic [31:0] hi_before, lo_before;
        hi_before = bus.Hi;
        lo_before = bus.Lo;
        seen = 1'b0;
        bus.Start = 1'b1; bus.Op = OP_MADD; bus.A = 32'd3; bus.B = 32'd4;
        @(negedge Clk);
        bus.Op = OP_MSUB;
        @(negedge Clk);
        bus.Start = 1'b0;
        for (int idx = 0; idx < 40; idx++) begin
            if (bus.Busy || bus.Done) seen = 1'b1;
            @(negedge Clk);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL madd_ignored_busy: got activity=%b, required 0", seen);
        end
        n_checks++;
        if ({bus.Hi, bus.Lo} !== {hi_before, lo_before}) begin
            n_fail++;
            $display("FAIL madd_ignored_hilo: got %h_%h, required %h_%h",
                     bus.Hi, bus.Lo, hi_before, lo_before);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_move();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
`ifdef MULDIV_MADD_EN
        test_madd();
`else
        test_madd_ignored();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
